// File: rtl/itcm_loader_pkg.sv
// Shared state encoding and image-format constants for the ITCM boot loader.
package itcm_loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO = 3'd0,
    HDR_HI = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/itcm_loader_asm.sv
// Little-endian 4-byte word assembler; word/word_valid are registered and
// update only when the 4th byte lands, so they can drive the ITCM directly.
module itcm_loader_asm
  import itcm_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_idx,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx   <= '0;
      sr         <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_idx <= '0;
        sr       <= '0;
      end else if (byte_valid) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0: sr[7:0]   <= byte_data;
          2'd1: sr[15:8]  <= byte_data;
          2'd2: sr[23:16] <= byte_data;
          default: begin
            word       <= {byte_data, sr};
            word_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/itcm_loader.sv
// Boot loader: byte stream -> ITCM write port, holds core in reset until done.
// Define ITCM_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module itcm_loader
  import itcm_loader_pkg::*;
#(
  parameter int AW       = 12,
  parameter int DW       = 32,
  parameter int ADDR_INC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          reload,
  output logic [AW-1:0] itcm_WADDR,
  output logic [DW-1:0] itcm_WDATA,
  output logic          itcm_WEN,
  output logic          core_rst_n,
  output logic          done,
  output logic          err
);

  localparam int HDR_BITS = 8 * HDR_BYTES;
`ifdef ITCM_LOADER_CSUM_EN
  localparam state_t END_ST = CSUM;
`else
  localparam state_t END_ST = DONE;
`endif

  state_t              state, state_nxt;
  logic                in_ready_d, done_d, err_d;
  logic                hs, reload_acc, asm_last, too_big;
  logic [7:0]          cnt_lo;
  logic [HDR_BITS-1:0] hdr_cnt, words_left;
  logic [1:0]          byte_idx;
`ifdef ITCM_LOADER_CSUM_EN
  logic [7:0]          csum_q;
`endif

  assign hs         = in_valid & in_ready;
  assign reload_acc = reload & ((state == DONE) | (state == ERR));
  assign hdr_cnt    = {in_data, cnt_lo};
  assign too_big    = 32'(hdr_cnt) > (32'd1 << AW);
  assign asm_last   = (byte_idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HDR_LO;
      in_ready   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready   <= in_ready_d;
      done       <= done_d;
      err        <= err_d;
      core_rst_n <= done_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HDR_LO: if (hs) state_nxt = HDR_HI;
      HDR_HI: begin
        if (hs) begin
          if (hdr_cnt == '0)  state_nxt = END_ST;
          else if (too_big)   state_nxt = ERR;
          else                state_nxt = DATA;
        end
      end
      DATA: if (hs && asm_last && words_left == HDR_BITS'(1)) state_nxt = END_ST;
`ifdef ITCM_LOADER_CSUM_EN
      CSUM: if (hs) state_nxt = (in_data == csum_q) ? DONE : ERR;
`endif
      DONE, ERR: if (reload) state_nxt = HDR_LO;
      default: state_nxt = HDR_LO;
    endcase
  end

  // Status lags state by a cycle so done never rises alongside the final WEN.
  always_comb begin
    in_ready_d = (state_nxt == HDR_LO) | (state_nxt == HDR_HI) |
                 (state_nxt == DATA)   | (state_nxt == CSUM);
    done_d     = (state == DONE) & (state_nxt == DONE);
    err_d      = (state == ERR)  & (state_nxt == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lo     <= '0;
      words_left <= '0;
      itcm_WADDR <= '0;
`ifdef ITCM_LOADER_CSUM_EN
      csum_q     <= '0;
`endif
    end else if (reload_acc) begin
      cnt_lo     <= '0;
      words_left <= '0;
      itcm_WADDR <= '0;
`ifdef ITCM_LOADER_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      if (hs && state == HDR_LO) cnt_lo <= in_data;
      if (hs && state == HDR_HI) words_left <= hdr_cnt;
      if (hs && state == DATA && asm_last) words_left <= words_left - HDR_BITS'(1);
      if (itcm_WEN) itcm_WADDR <= itcm_WADDR + AW'(ADDR_INC);
`ifdef ITCM_LOADER_CSUM_EN
      if (hs && (state == HDR_LO || state == HDR_HI || state == DATA))
        csum_q <= csum_q ^ in_data;
`endif
    end
  end

  itcm_loader_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (reload_acc),
    .byte_valid (hs && state == DATA),
    .byte_data  (in_data),
    .byte_idx   (byte_idx),
    .word       (itcm_WDATA),
    .word_valid (itcm_WEN)
  );

endmodule

// File: tb/tb_itcm_loader.sv
// Randomized bench for itcm_loader: images are parsed by a byte-level model
// into expected writes/status and compared with what the ITCM port shows.
module tb_itcm_loader;

  localparam int AW       = 12;
  localparam int ADDR_INC = 1;
  localparam int CAP      = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, in_valid, reload;
  logic [7:0]    in_data;
  logic          in_ready, itcm_WEN, core_rst_n, done, err;
  logic [AW-1:0] itcm_WADDR;
  logic [31:0]   itcm_WDATA;

  itcm_loader #(.AW(AW), .DW(32), .ADDR_INC(ADDR_INC)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .reload     (reload),
    .itcm_WADDR (itcm_WADDR),
    .itcm_WDATA (itcm_WDATA),
    .itcm_WEN   (itcm_WEN),
    .core_rst_n (core_rst_n),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    int            c;
  } wr_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         status_cyc;
  int         stalls;
  int         exp_used;
  bit         exp_err;
  wr_t        got_q[$];
  wr_t        exp_q[$];
  int         hs_cyc[$];
  logic [7:0] img_q[$];
  logic [7:0] saved_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (itcm_WEN) got_q.push_back('{itcm_WADDR, itcm_WDATA, cyc});
    if (status_cyc < 0 && (done || err)) status_cyc = cyc;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: parse header, slice little-endian words, verify optional checksum.
  function automatic void build_expect();
    int n;
    logic [31:0] d;
`ifdef ITCM_LOADER_CSUM_EN
    logic [7:0] x;
`endif
    n = int'({img_q[1], img_q[0]});
    exp_q.delete();
    exp_err = 1'b0;
    if (n > CAP) begin
      exp_err  = 1'b1;
      exp_used = 2;
      return;
    end
    for (int k = 0; k < n; k++) begin
      d = {img_q[4*k+5], img_q[4*k+4], img_q[4*k+3], img_q[4*k+2]};
      exp_q.push_back('{AW'((k * ADDR_INC) % CAP), d, 0});
    end
    exp_used = 2 + 4 * n;
`ifdef ITCM_LOADER_CSUM_EN
    x = 8'h00;
    for (int i = 0; i < exp_used; i++) x = x ^ img_q[i];
    exp_err  = (img_q[exp_used] != x);
    exp_used = exp_used + 1;
`endif
  endfunction

  function automatic void add_csum();
`ifdef ITCM_LOADER_CSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (img_q[i]) x = x ^ img_q[i];
    img_q.push_back(x);
`endif
  endfunction

  function automatic void make_image(input int n);
    img_q.delete();
    img_q.push_back(n[7:0]);
    img_q.push_back(n[15:8]);
    for (int i = 0; i < 4 * n; i++) img_q.push_back(8'($urandom));
    add_csum();
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit noisy);
    bit ok;
    int tries;
    ok = 1'b0;
    tries = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        reload   = noisy && ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!ok && tries < 50) begin
      reload = noisy && ($urandom_range(0, 3) == 0);
      ok = in_ready;
      @(posedge clk); #1;
      tries++;
      if (!ok) stalls++;
    end
    if (!ok) check_eq("byte_accept_timeout", ok, 1);
    else hs_cyc.push_back(cyc);
    in_valid = 1'b0;
    reload   = 1'b0;
  endtask

  task automatic run_image(input string tag, input bit gaps, input bit noisy);
    int nchk;
    got_q.delete();
    hs_cyc.delete();
    stalls     = 0;
    status_cyc = -1;
    build_expect();
    for (int i = 0; i < exp_used; i++) send_byte(img_q[i], gaps, noisy);
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, "_nwr"}, got_q.size(), exp_q.size());
    nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < nchk; k++) begin
      check_eq({tag, "_waddr"}, got_q[k].a, exp_q[k].a);
      check_eq({tag, "_wdata"}, got_q[k].d, exp_q[k].d);
      if (hs_cyc.size() > 4 * k + 5) check_eq({tag, "_wen_cyc"}, got_q[k].c, hs_cyc[4*k+5]);
    end
    check_eq({tag, "_done"}, done, !exp_err);
    check_eq({tag, "_err"}, err, exp_err);
    check_eq({tag, "_core_rst_n"}, core_rst_n, !exp_err);
    check_eq({tag, "_in_ready_end"}, in_ready, 0);
    if (hs_cyc.size() > 0) check_eq({tag, "_status_cyc"}, status_cyc, hs_cyc[$] + 1);
    if (!gaps) check_eq({tag, "_stalls"}, stalls, 0);
    // Bytes offered while finished must be ignored.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq({tag, "_idle_nwr"}, got_q.size(), exp_q.size());
    check_eq({tag, "_idle_status"}, {done, err}, {!exp_err, exp_err});
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    check_eq({tag, "_rl_in_ready"}, in_ready, 1);
    check_eq({tag, "_rl_status"}, {done, err, core_rst_n}, 3'b000);
    check_eq({tag, "_rl_waddr"}, itcm_WADDR, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    reload     = 1'b0;
    status_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", {in_ready, itcm_WEN, core_rst_n, done, err}, 5'b0);
    check_eq("reset_waddr", itcm_WADDR, 0);
    check_eq("reset_wdata", itcm_WDATA, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("in_ready_after_rst", in_ready, 1);

    img_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    add_csum();
    run_image("two_word", 0, 0);

    img_q = '{8'h00, 8'h00};
    add_csum();
    run_image("zero_cnt", 0, 0);

    img_q = '{8'h01, 8'h10};
    run_image("too_big", 0, 0);

    make_image(3);
    saved_q = img_q;
    run_image("r3_flat", 0, 0);
    img_q = saved_q;
    run_image("r3_gaps", 1, 1);

    // Abort part-way through the second word, then reload a fresh image.
    make_image(3);
    got_q.delete();
    for (int i = 0; i < 7; i++) send_byte(img_q[i], 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrst_outputs", {in_ready, itcm_WEN, core_rst_n, done, err}, 5'b0);
    check_eq("midrst_waddr", itcm_WADDR, 0);
    check_eq("midrst_wdata", itcm_WDATA, 0);
    check_eq("midrst_nwr", got_q.size(), 1);
    @(posedge clk); #1;
    check_eq("midrst_in_ready", in_ready, 1);
    make_image(3);
    run_image("post_rst", 0, 0);

`ifdef ITCM_LOADER_CSUM_EN
    img_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    run_image("csum_ok", 0, 0);
    img_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    run_image("csum_bad", 0, 0);
`endif

    for (int r = 0; r < 4; r++) begin
      make_image($urandom_range(1, 5));
      run_image("rand", 1, 1);
    end

    make_image(CAP);
    run_image("full_cap", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
